// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor: unpack/align, add/count, normalise/round/pack.
// Subnormals flush to zero. A caller tag and the exception flags travel with each result.
module fpu_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_sub,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [4:0]           out_flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;
  localparam int SW  = MW + 1;
  localparam int LZW = $clog2(SW + 1);
  localparam int EW  = EXP_W + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  // S1: classify, flush, swap, align
  logic [EXP_W-1:0] ea, eb, e_hi, e_lo, e_diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma, mb, m_hi, m_lo, m_sh;
  logic             sa, sb, s_hi, s_lo, swap;
  logic             inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, inf_clash;
  logic             spec, spec_nv;
  logic [W-1:0]     spec_res;

  always_comb begin
    sa = in_a[W-1];
    sb = in_b[W-1] ^ in_sub;
    ea = in_a[MAN_W +: EXP_W];
    eb = in_b[MAN_W +: EXP_W];
    fa = in_a[MAN_W-1:0];
    fb = in_b[MAN_W-1:0];
    inf_a  = (ea == EXP_MAX) && (fa == '0);
    inf_b  = (eb == EXP_MAX) && (fb == '0);
    nan_a  = (ea == EXP_MAX) && (fa != '0);
    nan_b  = (eb == EXP_MAX) && (fb != '0);
    snan_a = nan_a && !fa[MAN_W-1];
    snan_b = nan_b && !fb[MAN_W-1];
    ma = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
    mb = (eb == '0) ? '0 : {1'b1, fb, 3'b000};
    swap = {eb, mb} > {ea, ma};
    e_hi = swap ? eb : ea;
    e_lo = swap ? ea : eb;
    m_hi = swap ? mb : ma;
    m_lo = swap ? ma : mb;
    s_hi = swap ? sb : sa;
    s_lo = swap ? sa : sb;
    e_diff = e_hi - e_lo;
    if (int'(e_diff) >= MAN_W + 3) begin
      m_sh = {{(MW-1){1'b0}}, |m_lo};
    end else begin
      m_sh = m_lo >> e_diff;
      m_sh[0] = m_sh[0] | (|(m_lo & ~({MW{1'b1}} << e_diff)));
    end
    inf_clash = inf_a && inf_b && (sa != sb);
    spec      = nan_a || nan_b || inf_a || inf_b;
    spec_nv   = snan_a || snan_b || inf_clash;
    if (nan_a || nan_b || inf_clash) spec_res = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
    else if (inf_a)                  spec_res = {sa, EXP_MAX, {MAN_W{1'b0}}};
    else                             spec_res = {sb, EXP_MAX, {MAN_W{1'b0}}};
  end

  logic             s1_valid, s1_sign, s1_sub, s1_zsign, s1_spec, s1_nv;
  logic [EXP_W-1:0] s1_exp;
  logic [MW-1:0]    s1_ma, s1_mb;
  logic [W-1:0]     s1_spec_res;
  logic [TAG_W-1:0] s1_tag;

  // S2: magnitude add/subtract and leading-zero count
  function automatic logic [LZW-1:0] count_lz(input logic [SW-1:0] x);
    count_lz = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (x[i]) count_lz = LZW'(SW - 1 - i);
    end
  endfunction

  logic [SW-1:0]  sum;
  logic [LZW-1:0] lzc;
  always_comb begin
    sum = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
    lzc = count_lz(sum);
  end

  logic             s2_valid, s2_sign, s2_zsign, s2_spec, s2_nv;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sum;
  logic [LZW-1:0]   s2_lzc;
  logic [W-1:0]     s2_spec_res;
  logic [TAG_W-1:0] s2_tag;

  // S3: the leading one lands on the top bit of t, so carry-out and cancellation share one path
  logic [SW-1:0]    t;
  logic [MW-1:0]    n;
  logic [EW-1:0]    e_norm, e_rnd;
  logic [MAN_W:0]   rnd;
  logic             g, r, s, inc;
  logic [W-1:0]     res;
  logic [4:0]       flags;

  always_comb begin
    t      = s2_sum << s2_lzc;
    n      = {t[SW-1:2], |t[1:0]};
    e_norm = EW'(s2_exp) + EW'(1) - EW'(s2_lzc);
    g      = n[2];
    r      = n[1];
    s      = n[0];
    inc    = g && (r || s || n[3]);
    rnd    = {1'b0, n[MW-2:3]} + {{MAN_W{1'b0}}, inc};
    e_rnd  = e_norm + {{(EW-1){1'b0}}, rnd[MAN_W]};
    if (s2_spec) begin
      res   = s2_spec_res;
      flags = {s2_nv, 4'b0000};
    end else if (!t[SW-1]) begin
      res   = {s2_zsign, {(W-1){1'b0}}};
      flags = 5'b00000;
    end else if (e_norm[EW-1] || (e_norm == '0)) begin
      res   = {s2_sign, {(W-1){1'b0}}};
      flags = 5'b00011;
    end else if (e_rnd >= {2'b00, EXP_MAX}) begin
      res   = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      flags = 5'b00101;
    end else begin
      res   = {s2_sign, e_rnd[EXP_W-1:0], rnd[MAN_W-1:0]};
      flags = {4'b0000, g | r | s};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (en) begin
      s1_valid   <= in_valid;
      s2_valid   <= s1_valid;
      out_valid  <= s2_valid;
      out_result <= res;
      out_tag    <= s2_tag;
      out_flags  <= flags;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign     <= s_hi;
      s1_sub      <= s_hi ^ s_lo;
      s1_zsign    <= sa & sb;
      s1_exp      <= e_hi;
      s1_ma       <= m_hi;
      s1_mb       <= m_sh;
      s1_spec     <= spec;
      s1_nv       <= spec_nv;
      s1_spec_res <= spec_res;
      s1_tag      <= in_tag;
      s2_sign     <= s1_sign;
      s2_zsign    <= s1_zsign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum;
      s2_lzc      <= lzc;
      s2_spec     <= s1_spec;
      s2_nv       <= s1_nv;
      s2_spec_res <= s1_spec_res;
      s2_tag      <= s1_tag;
    end
  end
endmodule
